// File: rtl/traffic_sensor_conditioner_pkg.sv
// Shared definitions for the traffic sensor conditioner: channel state encodings
// and default timing values.
package traffic_sensor_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_QUAL    = 2'b01,
    ST_PRESENT = 2'b10,
    ST_HOLD    = 2'b11
  } sensor_state_t;

  localparam int DEF_DEB_CYCLES   = 4;
  localparam int DEF_HOLD_CYCLES  = 8;
  localparam int DEF_FAULT_CYCLES = 255;

endpackage

// File: rtl/sensor_channel.sv
// One detector channel: 2-flop synchronizer, debounce/hold FSM and, when
// TL_SENSOR_FAULT_EN is defined, a sticky stuck-sensor detector.
module sensor_channel
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CNT_W        = 4,
  parameter int FAULT_CYCLES = DEF_FAULT_CYCLES,
  parameter int FAULT_W      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic present,
  output logic fault
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  if (DEB_CYCLES < 2 || DEB_CYCLES > (1 << CNT_W) - 1) begin : g_bad_deb
    $error("DEB_CYCLES out of range for CNT_W");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > (1 << CNT_W) - 1) begin : g_bad_hold
    $error("HOLD_CYCLES out of range for CNT_W");
  end
  if (FAULT_CYCLES < 1 || FAULT_CYCLES > (1 << FAULT_W) - 1) begin : g_bad_fault
    $error("FAULT_CYCLES out of range for FAULT_W");
  end

  logic             sync_p0, sync_p1;
  sensor_state_t    state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             fault_nxt;

  // p0 -> p1: metastability filter on the asynchronous detector line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (sync_p1) begin
          state_nxt = ST_QUAL;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ST_QUAL: begin
        if (!sync_p1) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = ST_PRESENT;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_PRESENT: begin
        if (!sync_p1) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        if (sync_p1) begin
          state_nxt = ST_PRESENT;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
    // A stuck sensor parks the channel so the road reads as empty
    if (fault_nxt) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  // p1 -> state: FSM register with the output decoded from the next state
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      present <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      present <= (state_nxt == ST_PRESENT) || (state_nxt == ST_HOLD);
    end
  end

`ifdef TL_SENSOR_FAULT_EN
  localparam logic [FAULT_W-1:0] FAULT_LAST = FAULT_W'(FAULT_CYCLES);

  logic [FAULT_W-1:0] fcnt, fcnt_nxt;
  logic               fault_q;

  always_comb begin
    fcnt_nxt = fcnt;
    if (!sync_p1) begin
      fcnt_nxt = '0;
    end else if (fcnt != FAULT_LAST) begin
      fcnt_nxt = fcnt + 1'b1;
    end
    fault_nxt = fault_q || (fcnt_nxt == FAULT_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fcnt    <= '0;
      fault_q <= 1'b0;
    end else begin
      fcnt    <= fcnt_nxt;
      fault_q <= fault_nxt;
    end
  end

  assign fault = fault_q;
`else
  assign fault_nxt = 1'b0;
  assign fault     = 1'b0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions the road A/B loop detectors into clean ta/tb levels for the light
// controller. Define TL_SENSOR_FAULT_EN to build the stuck-sensor detectors.
module traffic_sensor_conditioner
  import traffic_sensor_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int CNT_W        = 4,
  parameter int FAULT_CYCLES = DEF_FAULT_CYCLES,
  parameter int FAULT_W      = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic ta,
  output logic tb,
  output logic fault_a,
  output logic fault_b
);

  sensor_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W),
    .FAULT_CYCLES(FAULT_CYCLES),
    .FAULT_W     (FAULT_W)
  ) u_chan_a (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_a),
    .present(ta),
    .fault  (fault_a)
  );

  sensor_channel #(
    .DEB_CYCLES  (DEB_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES),
    .CNT_W       (CNT_W),
    .FAULT_CYCLES(FAULT_CYCLES),
    .FAULT_W     (FAULT_W)
  ) u_chan_b (
    .clock  (clock),
    .reset  (reset),
    .raw    (raw_b),
    .present(tb),
    .fault  (fault_b)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner (DEB=4, HOLD=8, FAULT=20).
module tb_traffic_sensor_conditioner;

  logic clock = 1'b0;
  logic reset;
  logic raw_a, raw_b;
  logic ta, tb, fault_a, fault_b;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  traffic_sensor_conditioner #(
    .DEB_CYCLES  (4),
    .HOLD_CYCLES (8),
    .CNT_W       (4),
    .FAULT_CYCLES(20),
    .FAULT_W     (8)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .raw_a  (raw_a),
    .raw_b  (raw_b),
    .ta     (ta),
    .tb     (tb),
    .fault_a(fault_a),
    .fault_b(fault_b)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    raw_a = 1'b0;
    raw_b = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    #2 reset = 1'b0;
  endtask

  task automatic test_reset();
    raw_a = 1'b0;
    raw_b = 1'b0;
    reset = 1'b1;
    #2;
    checks++;
    if ({ta, tb, fault_a, fault_b} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_asserted got=%b exp=0000", {ta, tb, fault_a, fault_b});
    end
    tick();
    #2 reset = 1'b0;
    for (int e = 0; e < 20; e++) begin
      tick();
      checks++;
      if ({ta, tb, fault_a, fault_b} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_idle e=%0d got=%b exp=0000", e, {ta, tb, fault_a, fault_b});
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_ta;
    apply_reset();
    for (int e = 0; e <= 27; e++) begin
      raw_a = ((e >= 10) && (e <= 12)) || (e >= 20);
      tick();
      exp_ta = (e >= 25);
      checks++;
      if (ta !== exp_ta || tb !== 1'b0) begin
        failures++;
        $display("FAIL glitch e=%0d got ta=%b tb=%b exp ta=%b tb=0", e, ta, tb, exp_ta);
      end
    end
  endtask

  task automatic test_rise_fall();
    logic exp_ta, exp_tb;
    apply_reset();
    for (int e = 0; e <= 50; e++) begin
      raw_a = (e >= 10) && (e < 30);
      raw_b = (e >= 13) && (e < 33);
      tick();
      exp_ta = (e >= 15) && (e < 40);
      exp_tb = (e >= 18) && (e < 43);
      checks++;
      if (ta !== exp_ta || tb !== exp_tb) begin
        failures++;
        $display("FAIL rise_fall e=%0d got ta=%b tb=%b exp ta=%b tb=%b",
                 e, ta, tb, exp_ta, exp_tb);
      end
    end
  endtask

  task automatic test_dropout();
    logic exp_ta;
    apply_reset();
    for (int e = 0; e <= 32; e++) begin
      raw_a = (e >= 10) && !((e >= 20) && (e < 23));
      tick();
      exp_ta = (e >= 15);
      checks++;
      if (ta !== exp_ta) begin
        failures++;
        $display("FAIL dropout e=%0d got ta=%b exp ta=%b", e, ta, exp_ta);
      end
    end
  endtask

  task automatic test_async_reset();
    logic exp_ta;
    apply_reset();
    for (int e = 0; e <= 10; e++) begin
      raw_a = 1'b1;
      tick();
    end
    checks++;
    if (ta !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre got ta=%b exp ta=1", ta);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({ta, tb, fault_a, fault_b} !== 4'b0000) begin
      failures++;
      $display("FAIL areset_drop got=%b exp=0000", {ta, tb, fault_a, fault_b});
    end
    #2 reset = 1'b0;
    for (int e = 0; e <= 10; e++) begin
      tick();
      exp_ta = (e >= 5);
      checks++;
      if (ta !== exp_ta) begin
        failures++;
        $display("FAIL areset_requal e=%0d got ta=%b exp ta=%b", e, ta, exp_ta);
      end
    end
  endtask

  task automatic test_fault();
    logic exp_tb, exp_fb;
    apply_reset();
    for (int e = 0; e <= 60; e++) begin
      raw_b = (e >= 10) && (e <= 40);
      tick();
`ifdef TL_SENSOR_FAULT_EN
      exp_tb = (e >= 15) && (e < 31);
      exp_fb = (e >= 31);
`else
      exp_tb = (e >= 15) && (e < 51);
      exp_fb = 1'b0;
`endif
      checks++;
      if (tb !== exp_tb || fault_b !== exp_fb || ta !== 1'b0 || fault_a !== 1'b0) begin
        failures++;
        $display("FAIL fault e=%0d got tb=%b fault_b=%b ta=%b fault_a=%b exp tb=%b fault_b=%b ta=0 fault_a=0",
                 e, tb, fault_b, ta, fault_a, exp_tb, exp_fb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise_fall();
    test_dropout();
    test_async_reset();
    test_fault();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
